// File: rtl/coord_entry_seq.sv
// Turns PS/2 set-2 scan bytes into a held letter/number grid coordinate.
// Break and extended sequences are filtered out before the entry state machine sees them.
module coord_entry_seq #(
  parameter int MAX_COUNT = 100
) (
  input  logic       clock27,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  input  logic       consume,
  output logic       coord_valid,
  output logic [3:0] letter,
  output logic [3:0] number,
  output logic [1:0] entry_state,
  output logic       err,
  output logic [6:0] shot_count
);

  typedef enum logic [1:0] {
    WAIT_LETTER = 2'b00,
    WAIT_NUMBER = 2'b01,
    HOLD        = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    K_NONE, K_LETTER, K_NUMBER, K_ESC, K_BKSP, K_OTHER
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [3:0] idx;
  } code_t;

  function automatic code_t decode(input logic [7:0] b);
    code_t c;
    c.kind = K_LETTER;
    c.idx  = 4'd0;
    case (b)
      8'h1C: c.idx = 4'd0;
      8'h32: c.idx = 4'd1;
      8'h21: c.idx = 4'd2;
      8'h23: c.idx = 4'd3;
      8'h24: c.idx = 4'd4;
      8'h2B: c.idx = 4'd5;
      8'h34: c.idx = 4'd6;
      8'h33: c.idx = 4'd7;
      8'h43: c.idx = 4'd8;
      8'h3B: c.idx = 4'd9;
      8'h16: begin c.kind = K_NUMBER; c.idx = 4'd0; end
      8'h1E: begin c.kind = K_NUMBER; c.idx = 4'd1; end
      8'h26: begin c.kind = K_NUMBER; c.idx = 4'd2; end
      8'h25: begin c.kind = K_NUMBER; c.idx = 4'd3; end
      8'h2E: begin c.kind = K_NUMBER; c.idx = 4'd4; end
      8'h36: begin c.kind = K_NUMBER; c.idx = 4'd5; end
      8'h3D: begin c.kind = K_NUMBER; c.idx = 4'd6; end
      8'h3E: begin c.kind = K_NUMBER; c.idx = 4'd7; end
      8'h46: begin c.kind = K_NUMBER; c.idx = 4'd8; end
      8'h45: begin c.kind = K_NUMBER; c.idx = 4'd9; end
      8'h76: c.kind = K_ESC;
      8'h66: c.kind = K_BKSP;
      default: c.kind = K_OTHER;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] sat_inc(input logic [6:0] c);
    if (int'(c) >= MAX_COUNT) return c;
    return c + 7'd1;
  endfunction

  state_t     state, state_n, cur;
  logic       break_pend, ext_pend, break_pend_n, ext_pend_n;
  logic       valid_n, err_n;
  logic [3:0] letter_n, number_n;
  logic [6:0] count_n;
  code_t      code;
  kind_t      kind;

  always_comb begin
    state_n      = state;
    letter_n     = letter;
    number_n     = number;
    valid_n      = coord_valid;
    err_n        = 1'b0;
    count_n      = shot_count;
    break_pend_n = break_pend;
    ext_pend_n   = ext_pend;
    code         = decode(key_data);
    kind         = K_NONE;
    cur          = state;

    // byte filter: prefixes arm a skip of the following non-prefix byte
    if (key_valid) begin
      if (key_data == 8'hF0)          break_pend_n = 1'b1;
      else if (key_data == 8'hE0)     ext_pend_n   = 1'b1;
      else if (break_pend || ext_pend) begin
        break_pend_n = 1'b0;
        ext_pend_n   = 1'b0;
      end else                        kind = code.kind;
    end

    // consume retires the coordinate first; the same-cycle byte then sees WAIT_LETTER
    if (state == HOLD && consume && coord_valid) begin
      valid_n = 1'b0;
      count_n = sat_inc(shot_count);
      cur     = WAIT_LETTER;
      state_n = WAIT_LETTER;
    end

    case (cur)
      WAIT_LETTER: begin
        if (kind == K_LETTER) begin
          letter_n = code.idx;
          state_n  = WAIT_NUMBER;
        end else if (kind == K_NUMBER || kind == K_OTHER) begin
          err_n = 1'b1;
        end
      end
      WAIT_NUMBER: begin
        case (kind)
          K_NUMBER: begin
            number_n = code.idx;
            valid_n  = 1'b1;
            state_n  = HOLD;
          end
          K_LETTER:      letter_n = code.idx;
          K_ESC, K_BKSP: state_n  = WAIT_LETTER;
          K_OTHER:       err_n    = 1'b1;
          default:       ;
        endcase
      end
      HOLD: begin
        if (kind == K_ESC) begin
          valid_n = 1'b0;
          state_n = WAIT_LETTER;
        end else if (kind == K_LETTER || kind == K_NUMBER || kind == K_OTHER) begin
          err_n = 1'b1;
        end
      end
      default: state_n = WAIT_LETTER;
    endcase
  end

  always_ff @(posedge clock27) begin
    if (!reset_n) begin
      state       <= WAIT_LETTER;
      letter      <= 4'd0;
      number      <= 4'd0;
      coord_valid <= 1'b0;
      err         <= 1'b0;
      shot_count  <= 7'd0;
      break_pend  <= 1'b0;
      ext_pend    <= 1'b0;
    end else begin
      state       <= state_n;
      letter      <= letter_n;
      number      <= number_n;
      coord_valid <= valid_n;
      err         <= err_n;
      shot_count  <= count_n;
      break_pend  <= break_pend_n;
      ext_pend    <= ext_pend_n;
    end
  end

  assign entry_state = state;

endmodule
